// File: rtl/instr_loader_mem.sv
// rtl/instr_loader_mem.sv - byte-stream program loader and combinational instruction memory
// Image: LEN_LO, LEN_HI, then LEN x {INS_LO, INS_HI}; reads open only once the image is complete.
module instr_loader_mem #(
    parameter int                 INSTR_W    = 9,
    parameter int                 DEPTH      = 256,
    parameter logic [INSTR_W-1:0] FILL_INSTR = '0
) (
    input  logic               CLK,
    input  logic               reset_ctrl,
    input  logic               load_valid,
    input  logic [7:0]         load_data,
    output logic               load_ready,
    input  logic [15:0]        instr_addr,
    output logic [INSTR_W-1:0] instr_out,
    output logic               prog_ready,
    output logic [15:0]        prog_len,
    output logic               load_err
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_INS_LO,
        S_INS_HI,
        S_DONE,
        S_ERR
    } state_t;

    state_t       state_q, state_d;
    logic [15:0]  len_q, len_d;
    logic [7:0]   lo_q, lo_d;
    logic [15:0]  wr_ptr_q, wr_ptr_d;
    logic [15:0]  prog_len_q, prog_len_d;
    logic         mem_we;
    logic         xfer;
    logic [15:0]  n_full;

    logic [INSTR_W-1:0] mem [DEPTH];

    assign load_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_INS_LO) || (state_q == S_INS_HI);
    assign xfer       = load_valid && load_ready;
    assign n_full     = {load_data, len_q[7:0]};

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        lo_d       = lo_q;
        wr_ptr_d   = wr_ptr_q;
        prog_len_d = prog_len_q;
        mem_we     = 1'b0;
        case (state_q)
            S_LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = load_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = load_data;
                    if (n_full == 16'd0) begin
                        state_d    = S_DONE;
                        prog_len_d = 16'd0;
                    end else if ({1'b0, n_full} > DEPTH_L) begin
                        state_d = S_ERR;
                    end else begin
                        state_d  = S_INS_LO;
                        wr_ptr_d = 16'd0;
                    end
                end
            end
            S_INS_LO: begin
                if (xfer) begin
                    lo_d    = load_data;
                    state_d = S_INS_HI;
                end
            end
            S_INS_HI: begin
                if (xfer) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 16'd1;
                    if (wr_ptr_q == len_q - 16'd1) begin
                        state_d    = S_DONE;
                        prog_len_d = len_q;
                    end else begin
                        state_d = S_INS_LO;
                    end
                end
            end
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_LEN_LO;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset_ctrl) begin
            state_q    <= S_LEN_LO;
            len_q      <= '0;
            lo_q       <= '0;
            wr_ptr_q   <= '0;
            prog_len_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            lo_q       <= lo_d;
            wr_ptr_q   <= wr_ptr_d;
            prog_len_q <= prog_len_d;
        end
    end

    // Memory is deliberately not cleared on reset; prog_len == 0 hides stale entries.
    always_ff @(posedge CLK) begin
        if (mem_we && !reset_ctrl) begin
            mem[wr_ptr_q[AW-1:0]] <= {load_data[INSTR_W-9:0], lo_q};
        end
    end

    assign prog_ready = (state_q == S_DONE);
    assign load_err   = (state_q == S_ERR);
    assign prog_len   = prog_len_q;
    assign instr_out  = (prog_ready && (instr_addr < prog_len_q)) ?
                        mem[instr_addr[AW-1:0]] : FILL_INSTR;

endmodule
